// File: rtl/pc_unpacker.sv
// PC-side word unpacker: a 2-entry skid FIFO feeding one output register that
// steers each word to the BD, FPGA or global route channel, dropping NOP and unknown codes.
module pc_unpacker #(
  parameter int unsigned NPCcode       = 8,
  parameter int unsigned NPCdata       = 24,
  parameter int unsigned NPCroute      = 11,
  parameter int unsigned NBDcodes      = 13,
  parameter int unsigned FPGA_CODE_MAX = 63,
  parameter int unsigned NOP_CODE      = 255,
  parameter int unsigned GO_HOME_rt    = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  pc_in_v_i,
  output logic                                  pc_in_a_o,
  input  logic [NPCroute+NPCcode+NPCdata-1:0]   pc_in_d_i,
  output logic                                  bd_out_v_o,
  input  logic                                  bd_out_a_i,
  output logic [NPCcode-1:0]                    bd_out_code_o,
  output logic [NPCdata-1:0]                    bd_out_data_o,
  output logic                                  fpga_out_v_o,
  input  logic                                  fpga_out_a_i,
  output logic [NPCcode-1:0]                    fpga_out_code_o,
  output logic [NPCdata-1:0]                    fpga_out_data_o,
  output logic                                  global_out_v_o,
  input  logic                                  global_out_a_i,
  output logic [NPCroute-1:0]                   global_out_route_o,
  output logic [NPCcode-1:0]                    global_out_code_o,
  output logic [NPCdata-1:0]                    global_out_data_o,
  output logic [15:0]                           unknown_count_o
);

  localparam int unsigned W = NPCroute + NPCcode + NPCdata;
  localparam logic [NPCcode-1:0]  BdLim   = NPCcode'(NBDcodes);
  localparam logic [NPCcode-1:0]  FpgaMax = NPCcode'(FPGA_CODE_MAX);
  localparam logic [NPCcode-1:0]  NopCode = NPCcode'(NOP_CODE);
  localparam logic [NPCroute-1:0] GoHome  = NPCroute'(GO_HOME_rt);

  typedef enum logic [1:0] {ClsBd, ClsFpga, ClsGlobal, ClsDrop} cls_e;

  // Stage A: skid FIFO
  logic [W-1:0]  mem_q [2];
  logic          rd_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          a_q;

  // Stage B: output register
  logic                b_full_q;
  cls_e                b_cls_q;
  logic [NPCroute-1:0] b_route_q;
  logic [NPCcode-1:0]  b_code_q;
  logic [NPCdata-1:0]  b_data_q;
  logic [15:0]         unk_q;

  logic [W-1:0]        head;
  logic [NPCroute-1:0] head_route;
  logic [NPCcode-1:0]  head_code;
  logic [NPCdata-1:0]  head_data;
  cls_e                head_cls;
  logic                head_unk, head_valid;
  logic                b_sel_a, b_xfer, b_free, push, pop, load;
  logic                wr_idx;

  always_comb begin
    head       = mem_q[rd_q];
    head_route = head[W-1 -: NPCroute];
    head_code  = head[NPCdata +: NPCcode];
    head_data  = head[NPCdata-1:0];
    head_unk   = 1'b0;
    // Route wins over code: foreign-board words are forwarded without inspection
    if (head_route != GoHome)     head_cls = ClsGlobal;
    else if (head_code < BdLim)   head_cls = ClsBd;
    else if (head_code <= FpgaMax) head_cls = ClsFpga;
    else begin
      head_cls = ClsDrop;
      head_unk = (head_code != NopCode);
    end
  end

  always_comb begin
    case (b_cls_q)
      ClsBd:     b_sel_a = bd_out_a_i;
      ClsFpga:   b_sel_a = fpga_out_a_i;
      ClsGlobal: b_sel_a = global_out_a_i;
      default:   b_sel_a = 1'b0;
    endcase
    head_valid = (cnt_q != 2'd0);
    b_xfer     = b_full_q & b_sel_a;
    b_free     = ~b_full_q | b_xfer;
    pop        = head_valid & ((head_cls == ClsDrop) | b_free);
    load       = head_valid & (head_cls != ClsDrop) & b_free;
    push       = pc_in_v_i & a_q;
    wr_idx     = rd_q ^ cnt_q[0];
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      a_q       <= 1'b0;
      b_full_q  <= 1'b0;
      b_cls_q   <= ClsBd;
      b_route_q <= '0;
      b_code_q  <= '0;
      b_data_q  <= '0;
      unk_q     <= '0;
    end else begin
      if (push) mem_q[wr_idx] <= pc_in_d_i;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
      a_q   <= (cnt_d < 2'd2);
      if (load) begin
        b_full_q  <= 1'b1;
        b_cls_q   <= head_cls;
        b_route_q <= head_route;
        b_code_q  <= head_code;
        b_data_q  <= head_data;
      end else if (b_xfer) begin
        b_full_q <= 1'b0;
      end
      if (pop && head_unk && (unk_q != 16'hFFFF)) unk_q <= unk_q + 16'd1;
    end
  end

  assign pc_in_a_o          = a_q;
  assign bd_out_v_o         = b_full_q & (b_cls_q == ClsBd);
  assign fpga_out_v_o       = b_full_q & (b_cls_q == ClsFpga);
  assign global_out_v_o     = b_full_q & (b_cls_q == ClsGlobal);
  assign bd_out_code_o      = b_code_q;
  assign bd_out_data_o      = b_data_q;
  assign fpga_out_code_o    = b_code_q;
  assign fpga_out_data_o    = b_data_q;
  assign global_out_route_o = b_route_q;
  assign global_out_code_o  = b_code_q;
  assign global_out_data_o  = b_data_q;
  assign unknown_count_o    = unk_q;

endmodule

// File: tb/tb_pc_unpacker.sv
// Directed self-checking bench for pc_unpacker: routing, drops, backpressure,
// mid-flight reset and unknown-count saturation.
module tb_pc_unpacker;

  logic        clk, rst;
  logic        pc_v, pc_a;
  logic [42:0] pc_d;
  logic        bd_v, bd_a, fpga_v, fpga_a, glob_v, glob_a;
  logic [7:0]  bd_code, fpga_code, glob_code;
  logic [23:0] bd_data, fpga_data, glob_data;
  logic [10:0] glob_route;
  logic [15:0] ucnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [42:0] bd_q[$], fpga_q[$], glob_q[$];
  int          bd_t[$];

  pc_unpacker dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .pc_in_v_i          (pc_v),
    .pc_in_a_o          (pc_a),
    .pc_in_d_i          (pc_d),
    .bd_out_v_o         (bd_v),
    .bd_out_a_i         (bd_a),
    .bd_out_code_o      (bd_code),
    .bd_out_data_o      (bd_data),
    .fpga_out_v_o       (fpga_v),
    .fpga_out_a_i       (fpga_a),
    .fpga_out_code_o    (fpga_code),
    .fpga_out_data_o    (fpga_data),
    .global_out_v_o     (glob_v),
    .global_out_a_i     (glob_a),
    .global_out_route_o (glob_route),
    .global_out_code_o  (glob_code),
    .global_out_data_o  (glob_data),
    .unknown_count_o    (ucnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only at posedge+2, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (bd_v && bd_a) begin
        bd_q.push_back({11'd0, bd_code, bd_data});
        bd_t.push_back(cyc);
      end
      if (fpga_v && fpga_a) fpga_q.push_back({11'd0, fpga_code, fpga_data});
      if (glob_v && glob_a) glob_q.push_back({glob_route, glob_code, glob_data});
    end
  end

  function automatic logic [42:0] mk(input logic [10:0] r, input logic [7:0] c,
                                     input logic [23:0] d);
    return {r, c, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [42:0] w);
    int n = 0;
    pc_v = 1'b1;
    pc_d = w;
    while (pc_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("send_accept", {63'd0, pc_a}, 64'd1);
    tick();
    pc_v = 1'b0;
  endtask

  task automatic clear_q();
    bd_q.delete();
    fpga_q.delete();
    glob_q.delete();
    bd_t.delete();
  endtask

  // Fill with bd_a low: returns number accepted over the given cycles.
  task automatic fill_stalled(input int cycles, output int acc);
    logic took;
    acc  = 0;
    pc_v = 1'b1;
    pc_d = mk(11'd0, 8'd1, 24'h000A00);
    for (int i = 0; i < cycles; i++) begin
      took = pc_a;
      tick();
      if (took) begin
        acc++;
        if (acc < 4) pc_d = mk(11'd0, 8'd1 + 8'(acc), 24'h000A00 + 24'(acc));
        else pc_v = 1'b0;
      end
    end
  endtask

  initial begin
    int acc;
    int n;
    logic took;
    rst = 1'b1; pc_v = 1'b0; pc_d = '0;
    bd_a = 1'b1; fpga_a = 1'b1; glob_a = 1'b1;
    #1;
    chk("rst_a", {63'd0, pc_a}, 64'd0);
    chk("rst_v", {61'd0, bd_v, fpga_v, glob_v}, 64'd0);
    chk("rst_data", {bd_code, bd_data, glob_route}, 64'd0);
    chk("rst_cnt", {48'd0, ucnt}, 64'd0);
    tick(2);
    rst = 1'b0;
    chk("a_before_edge", {63'd0, pc_a}, 64'd0);
    tick();
    chk("a_after_edge", {63'd0, pc_a}, 64'd1);

    // Single BD word latency
    send(mk(11'd0, 8'd5, 24'hABCDEF));
    chk("lat_not_yet", {63'd0, bd_v}, 64'd0);
    tick();
    chk("lat_bd_v", {63'd0, bd_v}, 64'd1);
    chk("lat_bd_word", {40'd0, bd_code, bd_data}, {40'd0, 8'd5, 24'hABCDEF});
    chk("lat_others_v", {62'd0, fpga_v, glob_v}, 64'd0);
    chk("lat_fpga_data", {40'd0, fpga_code, fpga_data}, {40'd0, 8'd5, 24'hABCDEF});
    tick(3);
    chk("lat_bd_cnt", 64'(bd_q.size()), 64'd1);
    clear_q();

    // Classification boundaries
    send(mk(11'd0, 8'd12, 24'h000001));
    send(mk(11'd0, 8'd13, 24'h000002));
    send(mk(11'd0, 8'd63, 24'h000003));
    send(mk(11'd0, 8'd64, 24'h000004));
    send(mk(11'd0, 8'd255, 24'h000005));
    tick(6);
    chk("cls_bd_n", 64'(bd_q.size()), 64'd1);
    chk("cls_fpga_n", 64'(fpga_q.size()), 64'd2);
    chk("cls_glob_n", 64'(glob_q.size()), 64'd0);
    if (bd_q.size() == 1) chk("cls_bd0", 64'(bd_q[0]), 64'(mk(11'd0, 8'd12, 24'h000001)));
    if (fpga_q.size() == 2) begin
      chk("cls_fpga0", 64'(fpga_q[0]), 64'(mk(11'd0, 8'd13, 24'h000002)));
      chk("cls_fpga1", 64'(fpga_q[1]), 64'(mk(11'd0, 8'd63, 24'h000003)));
    end
    chk("cls_unk", {48'd0, ucnt}, 64'd1);
    clear_q();

    // Global route
    send(mk(11'h005, 8'd3, 24'h123456));
    tick(4);
    chk("glob_n", 64'(glob_q.size()), 64'd1);
    chk("glob_bd_n", 64'(bd_q.size()), 64'd0);
    if (glob_q.size() == 1) chk("glob_word", 64'(glob_q[0]), 64'(mk(11'h005, 8'd3, 24'h123456)));
    clear_q();

    // Backpressure
    bd_a = 1'b0;
    fill_stalled(8, acc);
    chk("bp_acc", 64'(acc), 64'd3);
    chk("bp_a_low", {63'd0, pc_a}, 64'd0);
    chk("bp_bd_head", {56'd0, bd_code}, 64'd1);
    chk("bp_none_out", 64'(bd_q.size()), 64'd0);
    bd_a = 1'b1;
    n = 0;
    while (acc < 4 && n < 20) begin
      took = pc_a;
      tick();
      n++;
      if (took) begin
        acc++;
        pc_v = 1'b0;
      end
    end
    chk("bp_acc4", 64'(acc), 64'd4);
    tick(6);
    chk("bp_out_n", 64'(bd_q.size()), 64'd4);
    if (bd_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk("bp_order", 64'(bd_q[i]), 64'(mk(11'd0, 8'd1 + 8'(i), 24'h000A00 + 24'(i))));
      chk("bp_rate", 64'(bd_t[3] - bd_t[0]), 64'd3);
    end
    clear_q();

    // Reset with B full and A holding two words
    bd_a = 1'b0;
    fill_stalled(8, acc);
    chk("rr_acc", 64'(acc), 64'd3);
    rst  = 1'b1;
    pc_v = 1'b0;
    #1;
    chk("rr_v", {61'd0, bd_v, fpga_v, glob_v}, 64'd0);
    chk("rr_a", {63'd0, pc_a}, 64'd0);
    chk("rr_cnt", {48'd0, ucnt}, 64'd0);
    tick(2);
    rst  = 1'b0;
    bd_a = 1'b1;
    tick(5);
    chk("rr_no_out", 64'(bd_q.size()), 64'd0);
    send(mk(11'd0, 8'd7, 24'h777777));
    tick(4);
    chk("rr_new_n", 64'(bd_q.size()), 64'd1);
    if (bd_q.size() == 1) chk("rr_new", 64'(bd_q[0]), 64'(mk(11'd0, 8'd7, 24'h777777)));
    clear_q();

    // Unknown-count saturation from zero
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 65534; i++) send(mk(11'd0, 8'd100, 24'(i)));
    tick(4);
    chk("sat_fffe", {48'd0, ucnt}, 64'hFFFE);
    send(mk(11'd0, 8'd100, 24'h0));
    tick(4);
    chk("sat_ffff", {48'd0, ucnt}, 64'hFFFF);
    send(mk(11'd0, 8'd100, 24'h0));
    tick(4);
    chk("sat_hold", {48'd0, ucnt}, 64'hFFFF);
    chk("sat_no_out", 64'(bd_q.size() + fpga_q.size() + glob_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
